accum_ctrl: RTL and testbench

- Multi-cycle control FSM for the 16-bit accumulator datapath.
- Sequences fetch/decode/execute by driving the enables (E) and mux selects of the PC, IR and accumulator reg16 instances, the ALU op and memory read/write.
- Purely control: takes the IR opcode and the accumulator zero flag, and emits per-cycle control.
- Also keeps a saturating retired-instruction counter for bench and debug visibility.

---
 rtl/accum_ctrl_if.sv | 35 +++
 rtl/accum_ctrl.sv | 169 ++++++++++++++++
 tb/tb_accum_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/accum_ctrl_if.sv
// Control bundle between the accumulator sequencer (master) and the datapath (slave).
// Carries the opcode/flag inputs, the per-cycle enables, selects and strobes, and debug status.
interface accum_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [3:0]       ir_op;
    logic             acc_zero;
    logic             pc_en;
    logic             pc_src;
    logic             ir_en;
    logic             acc_en;
    logic [1:0]       acc_src;
    logic [2:0]       alu_op;
    logic             addr_src;
    logic             mem_read;
    logic             mem_write;
    logic             busy;
    logic             halted;
    logic             illegal;
    logic [2:0]       state_out;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  start, ir_op, acc_zero,
        output pc_en, pc_src, ir_en, acc_en, acc_src, alu_op, addr_src,
               mem_read, mem_write, busy, halted, illegal, state_out, instr_count
    );

    modport slave (
        output start, ir_op, acc_zero,
        input  pc_en, pc_src, ir_en, acc_en, acc_src, alu_op, addr_src,
               mem_read, mem_write, busy, halted, illegal, state_out, instr_count
    );
endinterface

// File: rtl/accum_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator machine.
// Outputs decode from the registered state and opcode; also counts retired instructions.
module accum_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic       CLK,
    input  logic       reset,
    accum_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_FETCH_WB = 3'd2,
        S_DECODE   = 3'd3,
        S_MEM_RD   = 3'd4,
        S_EXEC     = 3'd5,
        S_HALT     = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_LOADI = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ACC_MEM = 2'd0;
    localparam logic [1:0] ACC_ALU = 2'd1;
    localparam logic [1:0] ACC_IMM = 2'd2;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    state_t           state;
    state_t           next;
    logic             pc_en;
    logic             pc_src;
    logic             ir_en;
    logic             acc_en;
    logic [1:0]       acc_src;
    logic [2:0]       alu_op;
    logic             addr_src;
    logic             mem_read;
    logic             mem_write;
    logic             halted;
    logic             set_illegal;
    logic             retire;
    logic             illegal;
    logic [CNT_W-1:0] count;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        next        = state;
        pc_en       = 1'b0;
        pc_src      = 1'b0;
        ir_en       = 1'b0;
        acc_en      = 1'b0;
        acc_src     = ACC_MEM;
        alu_op      = ALU_PASS;
        addr_src    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        halted      = 1'b0;
        set_illegal = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) next = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                next     = S_FETCH_WB;
            end
            S_FETCH_WB: begin
                ir_en = 1'b1;
                pc_en = 1'b1;
                next  = S_DECODE;
            end
            S_DECODE: begin
                next = S_FETCH;
                case (bus.ir_op)
                    OP_NOP: ;
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: next = S_MEM_RD;
                    OP_STORE: begin
                        mem_write = 1'b1;
                        addr_src  = 1'b1;
                    end
                    OP_JMP: begin
                        pc_en  = 1'b1;
                        pc_src = 1'b1;
                    end
                    OP_JZ: begin
                        // The only output allowed to see acc_zero: a conditional PC load.
                        pc_en  = bus.acc_zero;
                        pc_src = 1'b1;
                    end
                    OP_LOADI: begin
                        acc_en  = 1'b1;
                        acc_src = ACC_IMM;
                    end
                    OP_HALT: next = S_HALT;
                    default: begin
                        next        = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                addr_src = 1'b1;
                next     = S_EXEC;
            end
            S_EXEC: begin
                acc_en = 1'b1;
                next   = S_FETCH;
                case (bus.ir_op)
                    OP_ADD: begin acc_src = ACC_ALU; alu_op = ALU_ADD; end
                    OP_SUB: begin acc_src = ACC_ALU; alu_op = ALU_SUB; end
                    OP_AND: begin acc_src = ACC_ALU; alu_op = ALU_AND; end
                    OP_OR:  begin acc_src = ACC_ALU; alu_op = ALU_OR;  end
                    default: ;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: next = S_IDLE;
        endcase
    end

    // An instruction retires on the edge that returns to FETCH from DECODE or EXEC.
    assign retire = ((state == S_DECODE) && (next == S_FETCH)) || (state == S_EXEC);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            illegal <= 1'b0;
            count   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= next;
            if (set_illegal) illegal <= 1'b1;
            if (retire && (count != '1)) count <= count + CNT_W'(1);
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.pc_src      = pc_src;
    assign bus.ir_en       = ir_en;
    assign bus.acc_en      = acc_en;
    assign bus.acc_src     = acc_src;
    assign bus.alu_op      = alu_op;
    assign bus.addr_src    = addr_src;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.busy        = (state != S_IDLE) && (state != S_HALT);
    assign bus.halted      = halted;
    assign bus.illegal     = illegal;
    assign bus.state_out   = state;
    assign bus.instr_count = count;
endmodule

// File: tb/tb_accum_ctrl.sv
// Directed bench for accum_ctrl: instruction sequencing, strobes, halt/illegal, async reset, counter saturation.
module tb_accum_ctrl;
    logic CLK;
    logic reset;
    logic reset4;

    int checks = 0;
    int errors = 0;

    accum_ctrl_if #(.CNT_W(16)) bus  ();
    accum_ctrl_if #(.CNT_W(4))  bus4 ();

    accum_ctrl #(.CNT_W(16)) dut  (.CLK(CLK), .reset(reset),  .bus(bus.master));
    accum_ctrl #(.CNT_W(4))  dut4 (.CLK(CLK), .reset(reset4), .bus(bus4.master));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        int expct;
        reset        = 1'b1;
        reset4       = 1'b1;
        bus.start    = 1'b0;
        bus.ir_op    = 4'h0;
        bus.acc_zero = 1'b0;
        bus4.start    = 1'b1;
        bus4.ir_op    = 4'h0;
        bus4.acc_zero = 1'b0;

        // 1: reset state, then idle with start low
        #2;
        check("rst_state",  32'(bus.state_out), 32'd0);
        check("rst_strobes", 32'({bus.pc_en, bus.pc_src, bus.ir_en, bus.acc_en, bus.acc_src,
                                  bus.alu_op, bus.addr_src, bus.mem_read, bus.mem_write}), 32'd0);
        check("rst_status", 32'({bus.busy, bus.halted, bus.illegal}), 32'd0);
        check("rst_count",  32'(bus.instr_count), 32'd0);
        #48 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_hold", 32'(bus.state_out), 32'd0);
        end

        // 2: ADD walks 1,2,3,4,5,1
        bus.start = 1'b1;
        bus.ir_op = 4'h3;
        step();
        check("add_fetch",      32'(bus.state_out), 32'd1);
        check("add_fetch_rd",   32'({bus.mem_read, bus.addr_src}), 32'b10);
        check("add_busy",       32'(bus.busy), 32'd1);
        step();
        check("add_fwb",        32'(bus.state_out), 32'd2);
        check("add_fwb_ctl",    32'({bus.ir_en, bus.pc_en, bus.pc_src}), 32'b110);
        step();
        check("add_decode",     32'(bus.state_out), 32'd3);
        step();
        check("add_memrd",      32'(bus.state_out), 32'd4);
        check("add_memrd_ctl",  32'({bus.mem_read, bus.addr_src}), 32'b11);
        step();
        check("add_exec",       32'(bus.state_out), 32'd5);
        check("add_exec_ctl",   32'({bus.acc_en, bus.acc_src, bus.alu_op}), 32'b1_01_001);
        check("add_exec_cnt",   32'(bus.instr_count), 32'd0);
        step();
        check("add_back",       32'(bus.state_out), 32'd1);
        check("add_count",      32'(bus.instr_count), 32'd1);

        // 3: JZ not taken, then taken
        bus.ir_op    = 4'h8;
        bus.acc_zero = 1'b0;
        step();
        step();
        check("jz0_decode",     32'(bus.state_out), 32'd3);
        check("jz0_pc",         32'({bus.pc_en, bus.pc_src}), 32'b01);
        step();
        check("jz0_back",       32'(bus.state_out), 32'd1);
        check("jz0_count",      32'(bus.instr_count), 32'd2);
        bus.acc_zero = 1'b1;
        step();
        step();
        check("jz1_pc",         32'({bus.pc_en, bus.pc_src}), 32'b11);
        step();
        check("jz1_count",      32'(bus.instr_count), 32'd3);

        // 4: STORE strobe lasts only DECODE, then an illegal opcode halts
        bus.ir_op = 4'h2;
        step();
        check("st_fwb_wr",      32'(bus.mem_write), 32'd0);
        step();
        check("st_dec_wr",      32'({bus.mem_write, bus.addr_src}), 32'b11);
        step();
        check("st_after_wr",    32'(bus.mem_write), 32'd0);
        check("st_count",       32'(bus.instr_count), 32'd4);
        bus.ir_op = 4'hA;
        step();
        step();
        check("ill_dec_flag",   32'(bus.illegal), 32'd0);
        step();
        check("ill_state",      32'(bus.state_out), 32'd7);
        check("ill_status",     32'({bus.halted, bus.illegal, bus.busy}), 32'b110);
        check("ill_count",      32'(bus.instr_count), 32'd4);
        for (int i = 0; i < 20; i++) begin
            step();
            check("halt_hold",  32'({bus.state_out, bus.halted}), 32'b111_1);
        end

        // 5: async reset in the middle of EXEC; first retire a NOP so the count is nonzero
        bus.start = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        check("rst2_illegal",   32'(bus.illegal), 32'd0);
        step();
        reset = 1'b0;
        bus.start = 1'b1;
        bus.ir_op = 4'h0;
        step();
        step();
        step();
        step();
        check("nop_count",      32'(bus.instr_count), 32'd1);
        bus.ir_op = 4'h1;
        step();
        step();
        step();
        step();
        check("ld_exec",        32'(bus.state_out), 32'd5);
        check("ld_exec_ctl",    32'({bus.acc_en, bus.acc_src, bus.alu_op, bus.busy}), 32'b1_00_000_1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_state",  32'(bus.state_out), 32'd0);
        check("mid_rst_ctl",    32'({bus.acc_en, bus.busy}), 32'b00);
        check("mid_rst_count",  32'(bus.instr_count), 32'd0);
        bus.start = 1'b0;
        step();
        reset = 1'b0;

        // 6: 4-bit counter saturates at 15 across 20 NOPs
        reset4 = 1'b0;
        step();
        check("sat_fetch",      32'(bus4.state_out), 32'd1);
        check("sat_start",      32'(bus4.instr_count), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            step();
            step();
            step();
            expct = (k > 15) ? 15 : k;
            check("sat_count",  32'(bus4.instr_count), 32'(expct));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
